// File: rtl/usb_fs_rx_pkg.sv
// Shared types and constants for the full-speed USB receive front-end.
package usb_fs_rx_pkg;

  // Encoding is {dp, dn} as seen after the synchronizer.
  typedef enum logic [1:0] {
    LsSe0 = 2'b00,
    LsK   = 2'b01,
    LsJ   = 2'b10,
    LsSe1 = 2'b11
  } line_state_e;

  // SYNC decoded LSB-first: seven zeros followed by a one.
  localparam logic [7:0]  SyncPattern = 8'h80;
  localparam int unsigned StuffLimit  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEop,
    StAbort
  } rx_state_e;

endpackage

// File: rtl/usb_fs_rx_if.sv
// Line inputs and packet-layer outputs of the receive front-end.
interface usb_fs_rx_if;
  logic       dp_i;
  logic       dn_i;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       line_se0;

  // Receiver side: samples the line, produces bytes.
  modport master (
    input  dp_i, dn_i,
    output rx_active, rx_valid, rx_data, rx_err, line_se0
  );

  // Line driver / packet-layer side.
  modport slave (
    output dp_i, dn_i,
    input  rx_active, rx_valid, rx_data, rx_err, line_se0
  );
endinterface

// File: rtl/usb_fs_rx_dpll.sv
// Input synchronizer, line-state decode and 4x oversampling bit-clock recovery.
module usb_fs_rx_dpll
  import usb_fs_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dp_i,
  input  logic        dn_i,
  output line_state_e line_state_o,
  output logic        bit_strobe_o
);

  logic [SYNC_STAGES-1:0] dp_sync_q, dn_sync_q;
  line_state_e            ls_raw, ls_q;
  logic [1:0]             phase_q, phase_d;

  // Synchronizer chain, preset to idle J so reset never looks like a transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_sync_q <= '1;
      dn_sync_q <= '0;
    end else begin
      dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], dp_i};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], dn_i};
    end
  end

  assign ls_raw = line_state_e'({dp_sync_q[SYNC_STAGES-1], dn_sync_q[SYNC_STAGES-1]});

  // Any line transition realigns the phase; otherwise free-run modulo 4.
  always_comb begin
    phase_d = phase_q + 2'd1;
    if (ls_raw != ls_q) phase_d = 2'd0;
  end

  // Registered line state and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_q    <= LsJ;
      phase_q <= 2'd0;
    end else begin
      ls_q    <= ls_raw;
      phase_q <= phase_d;
    end
  end

  assign line_state_o = ls_q;
  assign bit_strobe_o = (phase_q == 2'(OVERSAMPLE / 2));

endmodule

// File: rtl/usb_fs_rx.sv
// Full-speed receive front-end: NRZI decode, unstuffing, SYNC/EOP framing, byte assembly.
module usb_fs_rx
  import usb_fs_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  usb_fs_rx_if.master  bus
);

  line_state_e line_state;
  logic        bit_strobe;

  usb_fs_rx_dpll #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dpll (
    .clk          (clk),
    .rst          (rst),
    .dp_i         (bus.dp_i),
    .dn_i         (bus.dn_i),
    .line_state_o (line_state),
    .bit_strobe_o (bit_strobe)
  );

  rx_state_e   state_q, state_d;
  line_state_e last_ls_q, last_ls_d;
  logic [2:0]  cnt_q, cnt_d;    // SYNC bit index, data bit index, or ABORT J run
  logic [2:0]  ones_q, ones_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        se0_seen_q, se0_seen_d;
  logic        rx_active_q, rx_active_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_err_q, rx_err_d;
  logic        line_se0_q;
  logic        nrzi_bit;
  logic        is_jk;

  assign nrzi_bit = (line_state == last_ls_q);
  assign is_jk    = (line_state == LsJ) || (line_state == LsK);

  // Next-state and output decode; everything advances only on a bit strobe.
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    shreg_d     = shreg_q;
    se0_seen_d  = se0_seen_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_err_d    = 1'b0;
    if (bit_strobe) begin
      last_ls_d = line_state;
      case (state_q)
        StIdle: begin
          if (line_state == LsK && last_ls_q == LsJ) begin
            state_d = StSync;
            cnt_d   = 3'd1;
          end
        end
        StSync: begin
          if (!is_jk || nrzi_bit != SyncPattern[cnt_q]) begin
            state_d = StIdle;
          end else if (cnt_q == 3'd7) begin
            state_d     = StData;
            rx_active_d = 1'b1;
            cnt_d       = 3'd0;
            // The trailing SYNC one starts the stuffing run.
            ones_d      = 3'd1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StData: begin
          if (line_state == LsSe0) begin
            state_d  = StEop;
            rx_err_d = (cnt_q != 3'd0);
          end else if (line_state == LsSe1 ||
                       (ones_q == 3'(StuffLimit) && nrzi_bit)) begin
            state_d    = StAbort;
            rx_err_d   = 1'b1;
            cnt_d      = 3'd0;
            se0_seen_d = 1'b0;
          end else if (ones_q == 3'(StuffLimit)) begin
            ones_d = 3'd0;  // stuffed zero, dropped
          end else begin
            ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            shreg_d = {nrzi_bit, shreg_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_valid_d = 1'b1;
              rx_data_d  = shreg_d;
            end
          end
        end
        StEop: begin
          if (line_state == LsJ) begin
            state_d     = StIdle;
            rx_active_d = 1'b0;
          end
        end
        StAbort: begin
          if (line_state == LsSe0) begin
            se0_seen_d = 1'b1;
            cnt_d      = 3'd0;
          end else if (line_state == LsJ) begin
            if (se0_seen_q || cnt_q == 3'd7) begin
              state_d     = StIdle;
              rx_active_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            se0_seen_d = 1'b0;
            cnt_d      = 3'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_ls_q   <= LsJ;
      cnt_q       <= 3'd0;
      ones_q      <= 3'd0;
      shreg_q     <= 8'h00;
      se0_seen_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_err_q    <= 1'b0;
      line_se0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      shreg_q     <= shreg_d;
      se0_seen_q  <= se0_seen_d;
      rx_active_q <= rx_active_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_err_q    <= rx_err_d;
      line_se0_q  <= (line_state == LsSe0);
    end
  end

  assign bus.rx_active = rx_active_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.line_se0  = line_se0_q;

endmodule

// File: doc/usb_fs_rx.md
Name: usb_fs_rx

Overview:
Synthesizable device-side USB 2.0 Full-Speed receive front-end. Consumes raw D+/D- line levels, recovers the 12 Mb/s bit clock by 4x oversampling at 48 MHz, and performs NRZI decode, bit unstuffing, SYNC/EOP detection and byte assembly. Delivers received packet bytes to the packet/PID layer in usb_fe. It is the counterpart of the bench host bit-level transmitter.

Parameters:
OVERSAMPLE, 4, clk cycles per USB bit time; only 4 supported (clk = 48 MHz).
SYNC_STAGES, 2, flip-flop depth of the dp/dn input synchronizer (>=2).

Ports:
clk  input  1  48 MHz clock
rst  input  1  asynchronous active-high reset
dp_i  input  1  raw D+ line level, asynchronous to clk
dn_i  input  1  raw D- line level, asynchronous to clk
rx_active  output  1  high from SYNC detection until EOP/abort handling completes
rx_valid  output  1  one-cycle strobe; rx_data holds a new byte
rx_data  output  8  received byte, LSB received first
rx_err  output  1  one-cycle strobe: stuff error, SE1, or non-byte-aligned EOP
line_se0  output  1  synchronized SE0 level, for bus-reset detection upstream

Behaviour:
- Reset: async, active-high. Outputs rx_active=0, rx_valid=0, rx_data=8'h00, rx_err=0, line_se0=0. Synchronizer preset to J (dp=1, dn=0). FSM to IDLE, phase counter to 0.
- Line state after synchronizer: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- DPLL: 2-bit phase counter increments every clk.
  - Any change of the synchronized state forces phase to 0.
  - Bit sample strobe fires when phase==2, i.e. mid-bit.
  - Must track a +-0.25% period error plus sub-ns jitter across a 7-bit run without stuffing.
- NRZI decode: at each strobe, bit=1 if the sampled state equals the previous strobe's state, else 0. SE0 is not decoded.
- FSM states:
  - IDLE: wait for a J->K strobe, then go to SYNC.
  - SYNC: expect KJKJKJKK, i.e. decoded 0000_0001 counted from the first K.
    - On the final KK, assert rx_active and go to DATA.
    - On a mismatch, return to IDLE silently; no rx_err, rx_active never raised.
  - DATA: shift decoded bits in LSB-first; after 8 kept bits, pulse rx_valid.
    - Ones counter: after six consecutive 1s the next bit is dropped if 0.
    - If that next bit is 1: pulse rx_err and go to ABORT.
    - SE0 at a strobe goes to EOP.
    - SE1 at a strobe: pulse rx_err, go to ABORT.
  - EOP: wait for the first J strobe, then deassert rx_active and go to IDLE.
    - If the bit count within the current byte is nonzero on SE0 entry, pulse rx_err once. The partial byte is discarded.
    - A non-J, non-SE0 strobe here is ignored until J is seen.
  - ABORT: rx_active stays high until an SE0->J sequence, or 8 consecutive J strobes. Then deassert rx_active and go to IDLE.
- Timing:
  - rx_valid and rx_data are registered and update exactly one clk after the strobe that samples the 8th kept bit.
  - rx_data holds its value until the next byte.
  - rx_valid is never asserted while rx_active=0.
- line_se0 is registered and tracks the synchronized SE0 every clk, independent of the FSM.
- Reset mid-packet aborts immediately. No rx_valid or rx_err is emitted afterwards for that packet.
- rx_valid and rx_err never assert in the same cycle. rx_err takes priority for the byte in which the error occurs.

Decomposition:
- usb_pkg (shared): line-state enum {LS_J, LS_K, LS_SE0, LS_SE1}; SYNC_PATTERN = 8'h80 (LSB-first 0000_0001); STUFF_LIMIT = 6; rx FSM state enum.
- Sub-module usb_fs_rx_dpll: synchronizer, line-state decode, phase counter. Outputs line_state and bit_strobe.
- usb_fs_rx: NRZI decode, unstuffing, FSM and output registers.

Test Plan:
- SYNC + 0xA5 + EOP (SE0,SE0,J) at nominal period -> exactly one rx_valid with rx_data=0xA5. rx_active high from the SYNC KK through the EOP J. rx_err never asserted.
- SYNC + 0xFF,0x01 with the bench inserting a stuffed 0 after six 1s -> rx_valid 0xFF then 0x01; the stuffed bit is not counted; no rx_err.
- SYNC + seven consecutive 1s, no stuff bit -> rx_err pulse, no rx_valid for that byte. rx_active drops after the following EOP.
- SYNC + 0xC3 + 3 extra bits + EOP -> rx_valid for 0xC3, then one rx_err at SE0 entry.
- 64-byte random packet at period 83.125 ns and 83.541 ns with +-100 ps phase jitter -> all bytes match, zero rx_err.
- rst asserted mid-byte, then released, then a new SYNC + 0x5A + EOP -> all outputs return to reset values asynchronously. Next packet yields exactly one rx_valid with 0x5A.
- Held SE0 for 10 us -> line_se0=1 throughout. No rx_valid; rx_active remains 0 if SE0 starts from IDLE.
